adc_therm_conditioner: RTL and testbench

//  Front-end stage of the flash ADC, directly upstream of the 8:3 priority encoder.

---
 rtl/adc_therm_conditioner.sv | 195 +++++++++++++++++++
 tb/tb_adc_therm_conditioner.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_therm_conditioner.sv
// adc_therm_conditioner
// Flash-ADC front end: sequences the S/H switch, synchronises the 7 async
// comparator outputs, removes single-bit bubbles by 3-input majority and
// only presents a word once it has been stable (or the qualify window ran out).
//
// Optional feature macro: ADC_SYNC3_EN
//   defined   -> 3-flop comparator synchroniser (one extra cycle of sync latency)
//   undefined -> 2-flop comparator synchroniser
// FSM timing is identical in both builds.
//
// Output handshake: therm_valid is a one-cycle strobe with no back-pressure;
// therm_out, bubble_err and qual_timeout change in the strobe cycle and then
// hold until the next capture.
//
// dbg_state exposes the FSM state: 0 IDLE, 1 TRACK, 2 SETTLE, 3 QUALIFY, 4 PRESENT.
module adc_therm_conditioner #(
  parameter int TRACK_CYCLES  = 100,
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_CNT    = 4,
  parameter int QUAL_TIMEOUT  = 64,
  parameter int CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] comp_in,
  output logic       sh_hold,
  output logic       busy,
  output logic [7:0] therm_out,
  output logic       therm_valid,
  output logic       bubble_err,
  output logic       qual_timeout,
  output logic [2:0] dbg_state
);

`ifdef ADC_SYNC3_EN
  localparam int SYNC_DEPTH = 3;
`else
  localparam int SYNC_DEPTH = 2;
`endif

  // Last counter value of each timed phase (counter starts at 0 on entry).
  localparam logic [CNT_W-1:0] L_TRACK_LAST  = CNT_W'(TRACK_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_QUAL_LAST   = CNT_W'(QUAL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_STABLE      = CNT_W'(STABLE_CNT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRACK   = 3'd1,
    S_SETTLE  = 3'd2,
    S_QUALIFY = 3'd3,
    S_PRESENT = 3'd4
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [CNT_W-1:0]             r_cnt;
  logic [CNT_W-1:0]             r_stable;
  logic [CNT_W-1:0]             w_stable_next;
  logic [6:0]                   r_c_prev;
  logic                         r_bad_seen;
  logic [SYNC_DEPTH-1:0][6:0]   r_sync;
  logic [6:0]                   w_s;
  logic [8:0]                   w_ext;
  logic [6:0]                   w_c;
  logic [7:0]                   w_s_plus;
  logic                         w_raw_bad;
  logic                         w_stable_hit;
  logic                         w_timeout_hit;
  logic                         w_capture;
  logic [7:0]                   r_therm;
  logic                         r_bubble;
  logic                         r_qto;

  // Comparator synchroniser: each bit runs through SYNC_DEPTH flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= comp_in;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_s = r_sync[SYNC_DEPTH-1];

  // Pad with the implied s[-1]=1 below and s[7]=0 above, so w_ext[i+1] = s[i].
  assign w_ext = {1'b0, w_s, 1'b1};

  // Bubble correction: each bit becomes the majority of itself and its neighbours.
  always_comb begin
    w_c = '0;
    for (int i = 0; i < 7; i++) begin
      w_c[i] = (w_ext[i]   & w_ext[i+1]) |
               (w_ext[i]   & w_ext[i+2]) |
               (w_ext[i+1] & w_ext[i+2]);
    end
  end

  // A legal thermometer word is 2^k-1, i.e. has no set bit above a zero.
  assign w_s_plus  = {1'b0, w_s} + 8'd1;
  assign w_raw_bad = |({1'b0, w_s} & w_s_plus);

  // Run length of identical corrected words; the first QUALIFY cycle starts at 1.
  assign w_stable_next = ((r_stable == '0) || (w_c != r_c_prev)) ? CNT_W'(1)
                                                                  : r_stable + CNT_W'(1);
  assign w_stable_hit  = (w_stable_next == L_STABLE);
  assign w_timeout_hit = (r_cnt == L_QUAL_LAST);
  assign w_capture     = (r_state == S_QUALIFY) && (w_stable_hit || w_timeout_hit);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (en) w_state_next = S_TRACK;
      S_TRACK:   if (r_cnt == L_TRACK_LAST) w_state_next = S_SETTLE;
      S_SETTLE:  if (r_cnt == L_SETTLE_LAST) w_state_next = S_QUALIFY;
      S_QUALIFY: if (w_capture) w_state_next = S_PRESENT;
      S_PRESENT: w_state_next = en ? S_TRACK : S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    sh_hold     = 1'b0;
    busy        = 1'b1;
    therm_valid = 1'b0;
    dbg_state   = r_state;
    case (r_state)
      S_IDLE:    busy        = 1'b0;
      S_SETTLE:  sh_hold     = 1'b1;
      S_QUALIFY: sh_hold     = 1'b1;
      S_PRESENT: therm_valid = 1'b1;
      default:   ;
    endcase
  end

  // Shared phase counter: cleared on every state change and while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((w_state_next != r_state) || (r_state == S_IDLE)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Stability tracking and bubble accumulation during QUALIFY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable   <= '0;
      r_c_prev   <= '0;
      r_bad_seen <= 1'b0;
    end else if (r_state == S_QUALIFY) begin
      r_stable   <= w_stable_next;
      r_c_prev   <= w_c;
      r_bad_seen <= r_bad_seen | w_raw_bad;
    end else begin
      r_stable   <= '0;
      r_bad_seen <= 1'b0;
    end
  end

  // Capture of the presented word and its flags; held until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_therm  <= 8'h01;
      r_bubble <= 1'b0;
      r_qto    <= 1'b0;
    end else if (w_capture) begin
      r_therm  <= {w_c, 1'b1};
      r_bubble <= r_bad_seen | w_raw_bad;
      r_qto    <= ~w_stable_hit;
    end
  end

  assign therm_out    = r_therm;
  assign bubble_err   = r_bubble;
  assign qual_timeout = r_qto;

endmodule

// File: tb/tb_adc_therm_conditioner.sv
// Bench for adc_therm_conditioner: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a conversion-level model.
module tb_adc_therm_conditioner;

  localparam int TRACK  = 100;
  localparam int SETTLE = 16;
  localparam int STABLE = 4;
  localparam int QTO    = 64;
`ifdef ADC_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic [6:0] comp_in = '0;
  logic       sh_hold, busy, therm_valid, bubble_err, qual_timeout;
  logic [7:0] therm_out;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  adc_therm_conditioner #(
    .TRACK_CYCLES(TRACK), .SETTLE_CYCLES(SETTLE), .STABLE_CNT(STABLE),
    .QUAL_TIMEOUT(QTO), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .comp_in(comp_in),
    .sh_hold(sh_hold), .busy(busy), .therm_out(therm_out),
    .therm_valid(therm_valid), .bubble_err(bubble_err),
    .qual_timeout(qual_timeout), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_go    = 1'b0;
  bit         m_abort = 1'b0;
  bit         m_en    = 1'b0;
  logic [6:0] m_c;
  bit         m_bad;
  logic [6:0] m_sync [SYNC_N];
  logic       exp_sh = 1'b0, exp_busy = 1'b0, exp_valid = 1'b0, exp_bad = 1'b0, exp_to = 1'b0;
  logic [7:0] exp_therm = 8'h01;

  // Each corrected bit is 1 when at least two of {below, self, above} are 1;
  // below bit 0 counts as 1, above bit 6 counts as 0.
  function automatic logic [6:0] model_correct(input logic [6:0] s);
    logic [6:0] c;
    int ones;
    c = '0;
    for (int i = 0; i < 7; i++) begin
      ones = 0;
      for (int j = i - 1; j <= i + 1; j++) begin
        if (j < 0) ones++;
        else if (j <= 6 && s[j]) ones++;
      end
      c[i] = (ones >= 2);
    end
    return c;
  endfunction

  // Legal thermometer word: exactly the lowest popcount bits are set.
  function automatic bit model_bad(input logic [6:0] s);
    int n;
    n = $countones(s);
    return int'(s) != ((1 << n) - 1);
  endfunction

  // One clock edge as seen by the model: pre-edge corrected word and en,
  // then the synchroniser pipe advances.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_abort = 1'b1;
      return;
    end
    m_c   = model_correct(m_sync[SYNC_N-1]);
    m_bad = model_bad(m_sync[SYNC_N-1]);
    m_en  = en;
    for (int i = SYNC_N - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = comp_in;
  endtask

  // A chain of conversions starting right after en was seen in idle.
  task automatic convert();
    int         stable;
    bit         done;
    bit         bad_acc;
    logic [6:0] prev;
    forever begin
      exp_busy = 1'b1; exp_sh = 1'b0; exp_valid = 1'b0;
      repeat (TRACK) begin step(); if (m_abort) return; end
      exp_sh = 1'b1;
      repeat (SETTLE) begin step(); if (m_abort) return; end
      stable = 0; done = 1'b0; bad_acc = 1'b0; prev = '0;
      for (int k = 1; !done; k++) begin
        step();
        if (m_abort) return;
        bad_acc = bad_acc | m_bad;
        stable  = (k == 1 || m_c != prev) ? 1 : stable + 1;
        prev    = m_c;
        if (stable == STABLE) begin done = 1'b1; exp_to = 1'b0; end
        else if (k == QTO)    begin done = 1'b1; exp_to = 1'b1; end
      end
      exp_therm = {prev, 1'b1};
      exp_bad   = bad_acc;
      exp_sh    = 1'b0;
      exp_valid = 1'b1;
      step();
      if (m_abort) return;
      exp_valid = 1'b0;
      if (!m_en) begin
        exp_busy = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < SYNC_N; i++) m_sync[i] = '0;
    wait (m_go);
    forever begin
      if (m_abort) begin
        exp_sh = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0;
        exp_therm = 8'h01; exp_bad = 1'b0; exp_to = 1'b0;
        for (int i = 0; i < SYNC_N; i++) m_sync[i] = '0;
        m_abort = 1'b0;
        wait (rst_n === 1'b1);
      end
      exp_sh = 1'b0; exp_busy = 1'b0; exp_valid = 1'b0;
      m_en = 1'b0;
      while (!m_abort && !m_en) step();
      if (!m_abort) convert();
    end
  end

  // Per-cycle compare; while reset is held the reset values are expected.
  always @(negedge clk) begin
    if (m_go) begin
      if (rst_n)
        check("cycle_outputs",
              {19'd0, sh_hold, busy, therm_valid, therm_out, bubble_err, qual_timeout},
              {19'd0, exp_sh, exp_busy, exp_valid, exp_therm, exp_bad, exp_to});
      else
        check("cycle_outputs_in_reset",
              {19'd0, sh_hold, busy, therm_valid, therm_out, bubble_err, qual_timeout},
              {19'd0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0});
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] r_t;
  logic       r_b, r_to;
  int         r_lat, r_hold;

  // One conversion with en pulsed for a single sample (dropped in TRACK).
  // lat counts cycles from the cycle en was sampled to the therm_valid cycle.
  task automatic run_conv(input logic [6:0] val, input bit noise,
                          output logic [7:0] t, output logic b, output logic to,
                          output int lat, output int hold_n);
    bit got;
    comp_in = val;
    repeat (4) @(negedge clk);
    en = 1'b1;
    lat = 0; hold_n = 0; got = 1'b0; t = '0; b = 1'b0; to = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) en = 1'b0;
      if (sh_hold) hold_n++;
      if (therm_valid) begin
        got = 1'b1; t = therm_out; b = bubble_err; to = qual_timeout;
      end
      if (noise) comp_in = (comp_in == 7'h03) ? 7'h07 : 7'h03;
    end
    check("valid_seen", {31'd0, got}, 32'd1);
    @(negedge clk);
    check("idle_after_present", {31'd0, busy}, 32'd0);
  endtask

  function automatic logic [6:0] pick_word();
    logic [6:0] w;
    int k;
    k = $urandom_range(0, 7);
    w = 7'((1 << k) - 1);
    case ($urandom_range(0, 3))
      0: ;
      1: w[$urandom_range(0, 6)] = ~w[$urandom_range(0, 6)];
      2: w = 7'($urandom_range(0, 127));
      default: w = ($urandom_range(0, 1) == 1) ? 7'h7F : 7'h00;
    endcase
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    bit noise_mode;
    int hold;
    #3 rst_n = 1'b0;
    @(negedge clk);
    check("rst_therm_out", {24'd0, therm_out}, 32'h01);
    check("rst_ctrl", {28'd0, sh_hold, busy, therm_valid, bubble_err}, 32'd0);
    check("rst_qual_timeout", {31'd0, qual_timeout}, 32'd0);
    check("rst_state_idle", {29'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_go  = 1'b1;
    @(negedge clk);

    // Clean legal word: minimum latency, stability capture.
    run_conv(7'b0011111, 1'b0, r_t, r_b, r_to, r_lat, r_hold);
    check("clean_therm", {24'd0, r_t}, 32'h3F);
    check("clean_flags", {30'd0, r_b, r_to}, 32'd0);
    check("clean_latency", r_lat, TRACK + SETTLE + STABLE + 1);
    check("clean_hold_cycles", r_hold, SETTLE + STABLE);

    // 0010111: bit3 low between ones, bit4 high above a zero; majority gives 0001111.
    run_conv(7'b0010111, 1'b0, r_t, r_b, r_to, r_lat, r_hold);
    check("bubble_therm", {24'd0, r_t}, 32'h1F);
    check("bubble_flags", {30'd0, r_b, r_to}, 32'b10);

    // Word alternating every cycle never stabilises: forced capture at last QUALIFY cycle.
    run_conv(7'h03, 1'b1, r_t, r_b, r_to, r_lat, r_hold);
    check("noise_timeout", {30'd0, r_b, r_to}, 32'b01);
    check("noise_hold_cycles", r_hold, SETTLE + QTO);
    check("noise_latency", r_lat, TRACK + SETTLE + QTO + 1);
    check("noise_word_legal", {31'd0, (r_t == 8'h07 || r_t == 8'h0F)}, 32'd1);

    // Extremes.
    run_conv(7'h00, 1'b0, r_t, r_b, r_to, r_lat, r_hold);
    check("zero_therm", {24'd0, r_t}, 32'h01);
    check("zero_bubble", {31'd0, r_b}, 32'd0);
    run_conv(7'h7F, 1'b0, r_t, r_b, r_to, r_lat, r_hold);
    check("full_therm", {24'd0, r_t}, 32'hFF);
    check("full_bubble", {31'd0, r_b}, 32'd0);

    // Reset asserted mid-QUALIFY takes effect without waiting for a clock edge.
    comp_in = 7'h1F;
    en = 1'b1;
    hold = 0;
    for (int i = 0; i < 300 && hold < SETTLE + 2; i++) begin
      @(negedge clk);
      en = 1'b0;
      if (sh_hold) hold++;
    end
    check("reach_qualify", hold, SETTLE + 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_sh_hold", {31'd0, sh_hold}, 32'd0);
    check("midrst_therm_out", {24'd0, therm_out}, 32'h01);
    check("midrst_valid_busy", {30'd0, therm_valid, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized run: back-to-back conversions, en toggling, noisy and clean inputs.
    en = 1'b1;
    noise_mode = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) en = ~en;
      if ($urandom_range(0, 199) == 0) noise_mode = ~noise_mode;
      if (noise_mode) comp_in = 7'($urandom_range(0, 127));
      else if ($urandom_range(0, 15) == 0) comp_in = pick_word();
      if (cyc == 2500) #2 rst_n = 1'b0;
      if (cyc == 2504) rst_n = 1'b1;
    end

    en = 1'b0;
    hold = 0;
    for (int i = 0; i < 400 && busy; i++) begin
      @(negedge clk);
      hold++;
    end
    check("drain_to_idle", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
